streaming_extreme_reducer: RTL and testbench

//  Sequential, parametrised successor to the two-input activation-aware min/max cell.

---
 rtl/streaming_extreme_reducer.sv | 97 +++++++++
 tb/tb_streaming_extreme_reducer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/streaming_extreme_reducer.sv
// streaming_extreme_reducer: folds a streamed frame of signed, activation-gated candidates
// into their min or max, with winner index, active count and truncation flag.
module streaming_extreme_reducer #(
    parameter int  NUMBER_SIZE  = 4,
    parameter int  MAX_ELEMENTS = 16,
    localparam int IW           = $clog2(MAX_ELEMENTS),
    localparam int CW           = $clog2(MAX_ELEMENTS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUMBER_SIZE-1:0] in_number,
    input  logic                   in_activation,
    input  logic                   in_last,
    input  logic                   in_mode_max,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUMBER_SIZE-1:0] out_extreme,
    output logic                   out_activation,
    output logic [IW-1:0]          out_index,
    output logic [CW-1:0]          out_count,
    output logic                   out_truncated
);
    typedef enum logic {ACCUM, DONE} state_t;

    state_t                 r_state, w_next;
    logic                   r_first, r_mode, r_act, r_trunc;
    logic [NUMBER_SIZE-1:0] r_acc;
    logic [IW-1:0]          r_idx, r_win;
    logic [CW-1:0]          r_count;
    logic                   w_take, w_mode, w_limit, w_close, w_repl, w_release;

    assign w_take    = in_valid & in_ready;
    assign w_release = out_valid & out_ready;
    assign w_mode    = r_first ? in_mode_max : r_mode;
    assign w_limit   = r_idx == IW'(MAX_ELEMENTS - 1);
    assign w_close   = in_last | w_limit;
    // strict compare: ties keep the earlier beat
    assign w_repl    = in_activation & (~r_act |
                       (w_mode ? ($signed(in_number) > $signed(r_acc))
                               : ($signed(in_number) < $signed(r_acc))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ACCUM && w_take && w_close) w_next = DONE;
        if (r_state == DONE && out_ready)          w_next = ACCUM;
    end

    always_comb begin
        in_ready  = r_state == ACCUM;
        out_valid = r_state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first <= 1'b1;
            r_mode  <= 1'b0;
            r_act   <= 1'b0;
            r_trunc <= 1'b0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_win   <= '0;
            r_count <= '0;
        end else if (w_release) begin
            r_first <= 1'b1;
            r_act   <= 1'b0;
            r_trunc <= 1'b0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_win   <= '0;
            r_count <= '0;
        end else if (w_take) begin
            r_first <= w_close;
            r_mode  <= w_mode;
            r_act   <= r_act | in_activation;
            r_trunc <= w_limit & ~in_last;
            r_idx   <= r_idx + 1'b1;
            r_count <= r_count + CW'(in_activation);
            if (w_repl) begin
                r_acc <= in_number;
                r_win <= r_idx;
            end
        end
    end

    assign out_extreme    = r_acc;
    assign out_activation = r_act;
    assign out_index      = r_win;
    assign out_count      = r_count;
    assign out_truncated  = r_trunc;
endmodule

// File: tb/tb_streaming_extreme_reducer.sv
// tb_streaming_extreme_reducer: table-driven frames, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_streaming_extreme_reducer;
    localparam int N  = 4;
    localparam int M  = 16;
    localparam int IW = $clog2(M);
    localparam int CW = $clog2(M + 1);

    typedef struct packed {
        logic [4:0]          len;
        logic                mode;
        logic                last;
        logic [M-1:0][N-1:0] num;
        logic [M-1:0]        act;
        logic [N-1:0]        e_ext;
        logic [IW-1:0]       e_idx;
        logic [CW-1:0]       e_cnt;
        logic                e_act;
        logic                e_trunc;
    } vec_t;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          in_valid = 1'b0, in_activation = 1'b0, in_last = 1'b0, in_mode_max = 1'b0;
    logic [N-1:0]  in_number = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, out_activation, out_truncated;
    logic [N-1:0]  out_extreme;
    logic [IW-1:0] out_index;
    logic [CW-1:0] out_count;
    int            total = 0, bad = 0;
    vec_t          tbl[8];

    streaming_extreme_reducer #(.NUMBER_SIZE(N), .MAX_ELEMENTS(M)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_number(in_number), .in_activation(in_activation), .in_last(in_last),
        .in_mode_max(in_mode_max), .out_valid(out_valid), .out_ready(out_ready),
        .out_extreme(out_extreme), .out_activation(out_activation), .out_index(out_index),
        .out_count(out_count), .out_truncated(out_truncated)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: extreme value among active beats, winner = earliest beat holding it
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int best = 0, cnt = 0, idx = 0;
        bit found = 0;
        for (int i = 0; i < int'(v.len); i++) begin
            int x = $signed(v.num[i]);
            if (v.act[i]) begin
                cnt++;
                if (!found || (v.mode ? x > best : x < best)) best = x;
                found = 1;
            end
        end
        for (int i = int'(v.len) - 1; i >= 0; i--)
            if (v.act[i] && $signed(v.num[i]) == best) idx = i;
        r.e_ext   = found ? N'(best) : '0;
        r.e_idx   = IW'(idx);
        r.e_cnt   = CW'(cnt);
        r.e_act   = found;
        r.e_trunc = !v.last && v.len == 5'(M);
        return r;
    endfunction

    task automatic drive_beat(input logic [N-1:0] n, input logic a, input logic l, input logic md);
        @(negedge clk);
        check("in_ready_beat", in_ready, 1);
        in_valid = 1'b1; in_number = n; in_activation = a; in_last = l; in_mode_max = md;
    endtask

    task automatic check_result(input vec_t v, input string tag);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_ext"}, out_extreme, v.e_ext);
        check({tag, "_idx"}, out_index, v.e_idx);
        check({tag, "_cnt"}, out_count, v.e_cnt);
        check({tag, "_act"}, out_activation, v.e_act);
        check({tag, "_trunc"}, out_truncated, v.e_trunc);
    endtask

    // Stream a frame (optional idle gaps, later-beat mode randomised), then hold result
    task automatic run_frame(input vec_t v, input int hold, input bit gaps, input string tag);
        for (int i = 0; i < int'(v.len); i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            drive_beat(v.num[i], v.act[i], v.last && i == int'(v.len) - 1,
                       i == 0 ? v.mode : 1'($urandom));
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check_result(v, tag);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; in_number = N'($urandom); in_activation = 1'b1;
            @(negedge clk);
            check_result(v, {tag, "_hold"});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    function automatic vec_t mk(input int len, input bit mode, input bit last);
        vec_t v = '0;
        v.len = 5'(len); v.mode = mode; v.last = last;
        return v;
    endfunction

    initial begin
        vec_t v;
        // MIN, tie on -2: earlier beat wins
        v = mk(4, 0, 1);
        v.num[0] = 4'd3; v.num[1] = -4'sd2; v.num[2] = 4'd5; v.num[3] = -4'sd2; v.act[3:0] = 4'b1111;
        v.e_ext = -4'sd2; v.e_idx = 1; v.e_cnt = 4; v.e_act = 1; v.e_trunc = 0;
        tbl[0] = v;
        // MAX, inactive 7 ignored
        v = mk(3, 1, 1);
        v.num[0] = 4'd7; v.num[1] = -4'sd8; v.num[2] = 4'd2; v.act[2:0] = 3'b110;
        v.e_ext = 4'd2; v.e_idx = 2; v.e_cnt = 2; v.e_act = 1; v.e_trunc = 0;
        tbl[1] = v;
        // all inactive
        v = mk(2, 0, 1);
        v.num[0] = 4'd4; v.num[1] = -4'sd1; v.act[1:0] = 2'b00;
        v.e_ext = 0; v.e_idx = 0; v.e_cnt = 0; v.e_act = 0; v.e_trunc = 0;
        tbl[2] = v;
        // 16 beats without in_last, values -8..7, MIN
        v = mk(16, 0, 0);
        for (int i = 0; i < 16; i++) v.num[i] = N'(i - 8);
        v.act = '1;
        v.e_ext = -4'sd8; v.e_idx = 0; v.e_cnt = 16; v.e_act = 1; v.e_trunc = 1;
        tbl[3] = v;
        // MAX with tied 7s at beats 3 and 5
        v = mk(6, 1, 1);
        for (int i = 0; i < 6; i++) v.num[i] = -4'sd8;
        v.num[3] = 4'd7; v.num[5] = 4'd7; v.act[5:0] = 6'b111111;
        v.e_ext = 4'd7; v.e_idx = 3; v.e_cnt = 6; v.e_act = 1; v.e_trunc = 0;
        tbl[4] = v;
        // single beat
        v = mk(1, 0, 1);
        v.num[0] = -4'sd8; v.act[0] = 1'b1;
        v.e_ext = -4'sd8; v.e_idx = 0; v.e_cnt = 1; v.e_act = 1; v.e_trunc = 0;
        tbl[5] = v;
        // 16 beats with in_last on beat 15: not truncated; MAX reaches 7 only at the end
        v = mk(16, 1, 1);
        for (int i = 0; i < 16; i++) v.num[i] = N'(i - 8);
        v.act = 16'hAAAA;
        v.e_ext = 4'd7; v.e_idx = 15; v.e_cnt = 8; v.e_act = 1; v.e_trunc = 0;
        tbl[6] = v;
        // first beat inactive, later small actives decide
        v = mk(3, 0, 1);
        v.num[0] = -4'sd8; v.num[1] = 4'd0; v.num[2] = 4'd1; v.act[2:0] = 3'b110;
        v.e_ext = 4'd0; v.e_idx = 1; v.e_cnt = 2; v.e_act = 1; v.e_trunc = 0;
        tbl[7] = v;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", out_count, 0);
        check("rst_ext", out_extreme, 0);
        rst_n = 1'b1;

        for (int t = 0; t < 8; t++) run_frame(tbl[t], t == 3 ? 2 : 0, 0, $sformatf("tbl%0d", t));

        // backpressure 5 cycles on a MAX frame, then MIN frame whose later beats claim MAX
        run_frame(tbl[1], 5, 0, "bp_max");
        run_frame(tbl[0], 0, 0, "bp_next_min");

        // reset after 2 accepted beats discards the frame
        drive_beat(4'd6, 1'b1, 1'b0, 1'b1);
        drive_beat(4'd7, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_count", out_count, 0);
        check("midrst_act", out_activation, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(tbl[0], 0, 0, "after_rst");

        // reset while holding a result in DONE
        for (int i = 0; i < 2; i++) drive_beat(4'd5, 1'b1, i == 1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("done_before_rst", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("donerst_valid", out_valid, 0);
        check("donerst_ext", out_extreme, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(tbl[2], 0, 0, "after_done_rst");

        for (int r = 0; r < 60; r++) begin
            int len = $urandom_range(1, M);
            bit last = (len < M) || ($urandom_range(1) == 1);
            v = mk(len, 1'($urandom), last);
            for (int i = 0; i < M; i++) begin
                v.num[i] = N'($urandom);
                v.act[i] = $urandom_range(3) != 0;
            end
            run_frame(model(v), $urandom_range(3), 1, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
